// File: rtl/accu_alu_fetch_if.sv
// Bundle of the fetch/accumulator/ALU signals shared between driver and block.
interface accu_alu_fetch_if;
    logic       fetch_en;
    logic [7:0] program_byte;
    logic [3:0] instr;
    logic [3:0] oprnd;
    logic       load_a;
    logic [2:0] fun;
    logic [3:0] data_bus;
    logic [3:0] accu;
    logic [3:0] alu;
    logic       carry;
    logic       zero;

    // Driver side: supplies enables, program byte, ALU controls and operand B.
    modport master (
        output fetch_en, program_byte, load_a, fun, data_bus,
        input  instr, oprnd, accu, alu, carry, zero
    );

    // Block side: fetch register, accumulator and ALU.
    modport slave (
        input  fetch_en, program_byte, load_a, fun, data_bus,
        output instr, oprnd, accu, alu, carry, zero
    );
endinterface

// File: rtl/accu_alu_fetch.sv
// Instruction fetch register, 4-bit accumulator and combinational ALU.
// The accumulator feeds ALU operand A; a load captures the ALU result that
// was computed from the pre-edge accumulator, so there is no loop.
module accu_alu_fetch (
    input  logic             clock,
    input  logic             reset,
    accu_alu_fetch_if.slave  bus
);
    logic [3:0] instr_q, instr_d;
    logic [3:0] oprnd_q, oprnd_d;
    logic [3:0] accu_q,  accu_d;
    logic [3:0] alu_res;
    logic       alu_carry;
    logic [4:0] sum;

    // 5-bit sum shared by the add function to expose the carry-out.
    assign sum = {1'b0, accu_q} + {1'b0, bus.data_bus};

    // ALU: operand A is the accumulator, operand B the data bus.
    always_comb begin
        alu_res   = 4'b0000;
        alu_carry = 1'b0;
        case (bus.fun)
            3'b000: alu_res = accu_q;
            3'b001: begin
                alu_res   = accu_q - bus.data_bus;
                alu_carry = (accu_q < bus.data_bus);
            end
            3'b010: alu_res = bus.data_bus;
            3'b011: begin
                alu_res   = sum[3:0];
                alu_carry = sum[4];
            end
            3'b100: alu_res = ~(accu_q & bus.data_bus);
            default: begin
                alu_res   = 4'b0000;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Next-state selection for the fetch and accumulator registers.
    always_comb begin
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        accu_d  = accu_q;
        if (bus.fetch_en) begin
            instr_d = bus.program_byte[7:4];
            oprnd_d = bus.program_byte[3:0];
        end
        if (bus.load_a) begin
            accu_d = alu_res;
        end
    end

    // State registers; reset overrides both enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= 4'b0000;
            oprnd_q <= 4'b0000;
            accu_q  <= 4'b0000;
        end else begin
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            accu_q  <= accu_d;
        end
    end

    assign bus.instr = instr_q;
    assign bus.oprnd = oprnd_q;
    assign bus.accu  = accu_q;
    assign bus.alu   = alu_res;
    assign bus.carry = alu_carry;
    assign bus.zero  = (alu_res == 4'b0000);
endmodule

// File: tb/tb_accu_alu_fetch.sv
// Directed bench for accu_alu_fetch with hand-computed expectations.
module tb_accu_alu_fetch;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    accu_alu_fetch_if bus ();

    accu_alu_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.fetch_en     = 1'b1;
        bus.load_a       = 1'b1;
        bus.program_byte = 8'hFF;
        bus.fun          = 3'b010;
        bus.data_bus     = 4'hF;
        tick();
        // reset beats both enables
        chk("rst_instr", {4'h0, bus.instr}, 8'h00);
        chk("rst_oprnd", {4'h0, bus.oprnd}, 8'h00);
        chk("rst_accu",  {4'h0, bus.accu},  8'h00);
        bus.fun = 3'b000; bus.data_bus = 4'h0; #1;
        chk("rst_alu",   {4'h0, bus.alu},   8'h00);
        chk("rst_carry", {7'h0, bus.carry}, 8'h00);
        chk("rst_zero",  {7'h0, bus.zero},  8'h01);

        // fetch load then hold
        reset = 1'b0; bus.load_a = 1'b0;
        bus.program_byte = 8'hC7; bus.fetch_en = 1'b1;
        tick();
        chk("fetch_instr", {4'h0, bus.instr}, 8'h0C);
        chk("fetch_oprnd", {4'h0, bus.oprnd}, 8'h07);
        bus.fetch_en = 1'b0; bus.program_byte = 8'h3A;
        tick();
        chk("hold_instr", {4'h0, bus.instr}, 8'h0C);
        chk("hold_oprnd", {4'h0, bus.oprnd}, 8'h07);

        // pass-B load, then add overflowing to zero
        bus.fun = 3'b010; bus.data_bus = 4'h9; bus.load_a = 1'b1;
        tick();
        chk("ld_b_accu", {4'h0, bus.accu}, 8'h09);
        bus.fun = 3'b011; bus.data_bus = 4'h7; #1;
        chk("add_alu",   {4'h0, bus.alu},   8'h00);
        chk("add_carry", {7'h0, bus.carry}, 8'h01);
        chk("add_zero",  {7'h0, bus.zero},  8'h01);
        tick();
        chk("add_accu",  {4'h0, bus.accu},  8'h00);

        // subtract with and without borrow, A=3
        bus.fun = 3'b010; bus.data_bus = 4'h3;
        tick();
        chk("ld3_accu", {4'h0, bus.accu}, 8'h03);
        bus.load_a = 1'b0;
        bus.fun = 3'b001; bus.data_bus = 4'h5; #1;
        chk("sub_alu",   {4'h0, bus.alu},   8'h0E);
        chk("sub_carry", {7'h0, bus.carry}, 8'h01);
        chk("sub_zero",  {7'h0, bus.zero},  8'h00);
        bus.data_bus = 4'h3; #1;
        chk("sub0_alu",   {4'h0, bus.alu},   8'h00);
        chk("sub0_carry", {7'h0, bus.carry}, 8'h00);
        chk("sub0_zero",  {7'h0, bus.zero},  8'h01);

        // NAND and reserved codes, A=C
        bus.fun = 3'b010; bus.data_bus = 4'hC; bus.load_a = 1'b1;
        tick();
        chk("ldC_accu", {4'h0, bus.accu}, 8'h0C);
        bus.load_a = 1'b0;
        bus.fun = 3'b100; bus.data_bus = 4'hA; #1;
        chk("nand_alu",   {4'h0, bus.alu},   8'h07);
        chk("nand_carry", {7'h0, bus.carry}, 8'h00);
        bus.fun = 3'b110; #1;
        chk("f110_alu",  {4'h0, bus.alu},  8'h00);
        chk("f110_zero", {7'h0, bus.zero}, 8'h01);
        bus.fun = 3'b101; #1;
        chk("f101_alu",  {4'h0, bus.alu},  8'h00);
        bus.fun = 3'b111; bus.data_bus = 4'hF; #1;
        chk("f111_zero", {7'h0, bus.zero}, 8'h01);

        // accu holds while alu follows inputs
        bus.fun = 3'b011; bus.data_bus = 4'h1; #1;
        chk("hold_add_alu", {4'h0, bus.alu}, 8'h0D);
        tick();
        chk("hold_accu1", {4'h0, bus.accu}, 8'h0C);
        bus.fun = 3'b000; #1;
        chk("pass_a_alu", {4'h0, bus.alu}, 8'h0C);
        bus.fun = 3'b001; bus.data_bus = 4'hD; #1;
        chk("hold_sub_alu",   {4'h0, bus.alu},   8'h0F);
        chk("hold_sub_carry", {7'h0, bus.carry}, 8'h01);
        tick();
        chk("hold_accu2", {4'h0, bus.accu}, 8'h0C);
        bus.fun = 3'b011; bus.data_bus = 4'h5; #1;
        chk("add17_alu",   {4'h0, bus.alu},   8'h01);
        chk("add17_carry", {7'h0, bus.carry}, 8'h01);
        tick();
        chk("hold_accu3", {4'h0, bus.accu}, 8'h0C);

        // mid-sequence reset, then fetch and accu load together next edge
        reset = 1'b1;
        tick();
        chk("mid_rst_accu",  {4'h0, bus.accu},  8'h00);
        chk("mid_rst_instr", {4'h0, bus.instr}, 8'h00);
        reset = 1'b0; bus.load_a = 1'b1; bus.fun = 3'b010; bus.data_bus = 4'h6;
        bus.fetch_en = 1'b1; bus.program_byte = 8'h5B;
        tick();
        chk("both_accu",  {4'h0, bus.accu},  8'h06);
        chk("both_instr", {4'h0, bus.instr}, 8'h05);
        chk("both_oprnd", {4'h0, bus.oprnd}, 8'h0B);

        // reset asserted between edges must not act until the edge
        bus.load_a = 1'b0; bus.fetch_en = 1'b0;
        reset = 1'b1; #2;
        chk("sync_rst_pre", {4'h0, bus.accu}, 8'h06);
        tick();
        chk("sync_rst_post", {4'h0, bus.accu}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
